wb_writeback_unit: RTL and testbench
====================================

Name: wb_writeback_unit

Overview:
- Consumes the outputs of the write-back pipeline register and drives the register file's single write port and the PC load path.
- Serialises an instruction that needs two writes (result plus base-register update) into two consecutive write cycles.
- Stalls upstream stages for one cycle while it does so.
- Counts retired instructions.

Parameters:
- wb_control_width, 2, width of wb_control; bit0 = result write enable, bit1 = base-register update enable, higher bits ignored
- data_width, 32, width of all data paths
- pc_index, 15, register number treated as the PC

Ports:
- clock  input  1  system clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- wb_control  input  wb_control_width  write enables from write-back pipeline register
- wb_content  input  data_width  result value
- base_register_update_content  input  data_width  updated base value
- wb_add  input  4  result destination register
- reg_update_address  input  4  base register number
- stall  output  1  combinational; high = hold the write-back pipeline register and all upstream stages this cycle
- rf_we  output  1  registered register-file write enable
- rf_waddr  output  4  registered write address
- rf_wdata  output  data_width  registered write data
- pc_load  output  1  registered; PC must load pc_value
- pc_value  output  data_width  registered PC target
- retired_count  output  32  registered count of instructions with any write enable set

Behaviour:
- Reset: all outputs except stall clear to 0; state = IDLE; pending registers cleared. stall is 0 while reset_n is low. Reset asserted mid-operation (in PEND) discards the pending write.
- Derived signals: res = wb_control[0]; base = wb_control[1]; dual = res & base & (wb_add != reg_update_address).
- Collision: res & base with equal addresses counts as a single write. The result wins and the base update is dropped.
- Latency: a write selected at rising edge k appears on rf_* / pc_* after edge k. The register file commits it at edge k+1. Each write is a one-cycle pulse.
- Write routing: a selected write to pc_index drives pc_load=1 with pc_value = data, and rf_we=0. Any other address drives rf_we=1 with rf_waddr/rf_wdata. Otherwise all enables are 0, and address/data hold their previous values.
- FSM states: IDLE, PEND.
- IDLE, dual:
  - stall = 1 combinationally.
  - At the edge: emit the base update, latch wb_add and wb_content into the pending registers, go to PEND.
  - Ordering is base first, result second, so a loaded value is the final register content.
- IDLE, not dual:
  - stall = 0.
  - Emit the result if res, else the base update if base, else nothing. Stay in IDLE.
- PEND:
  - stall = 0. Inputs are ignored, because upstream re-presents the held instruction.
  - Emit the pending write. Go to IDLE.
- Retired count: retired_count increments by 1 at the edge where any write is first emitted for an instruction (IDLE with res|base). It does not increment in PEND. It wraps modulo 2^32.
- Consecutive dual instructions: each takes exactly 2 cycles, with no bubble inserted between them.

Test Plan:
1. Reset low with wb_control=2'b11 -> all outputs 0, stall 0. Release reset -> state IDLE, retired_count 0.
2. Single write: wb_control=01, wb_add=3, wb_content=0xDEADBEEF -> one cycle later rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF. Next cycle (control 00) rf_we=0. retired_count=1.
3. Dual write: wb_control=11, wb_add=2, wb_content=0x11, reg_update_address=5, base content=0x104, held for 2 cycles:
   - stall=1 in the first cycle only.
   - Writes in order: (5,0x104), then (2,0x11).
   - retired_count +1.
4. Collision: wb_control=11, both addresses 7, wb_content=0xA, base content=0xB -> single write (7,0xA), stall never asserted.
5. PC write: wb_control=01, wb_add=15, wb_content=0x8000 -> pc_load=1, pc_value=0x8000, rf_we=0 for one cycle. Dual instruction with base=15 -> first cycle pc_load, second cycle rf_we.
6. Reset mid-PEND: dual instruction accepted, then reset_n pulsed low in the PEND cycle -> no second write, outputs 0, next instruction handled from IDLE.

Source files
------------

// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: drives the register-file write port and PC load, splitting dual-write instructions over two cycles
module wb_writeback_unit #(
  parameter int wb_control_width = 2,
  parameter int data_width = 32,
  parameter int pc_index = 15
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [wb_control_width-1:0] wb_control,
  input  logic [data_width-1:0]       wb_content,
  input  logic [data_width-1:0]       base_register_update_content,
  input  logic [3:0]                  wb_add,
  input  logic [3:0]                  reg_update_address,
  output logic                        stall,
  output logic                        rf_we,
  output logic [3:0]                  rf_waddr,
  output logic [data_width-1:0]       rf_wdata,
  output logic                        pc_load,
  output logic [data_width-1:0]       pc_value,
  output logic [31:0]                 retired_count
);
  typedef enum logic {IDLE, PEND} state_t;
  state_t state;
  logic [3:0] pend_addr;
  logic [data_width-1:0] pend_data;
  logic res, base, dual, sel_we, sel_pc;
  logic [3:0] sel_addr;
  logic [data_width-1:0] sel_data;
  assign res = wb_control[0];
  assign base = wb_control[1];
  assign dual = res & base & (wb_add != reg_update_address);
  assign stall = reset_n & (state == IDLE) & dual;
  // base update goes first so the result is the register's final value
  always_comb begin
    sel_we = (state == PEND) | res | base;
    sel_addr = (state == PEND) ? pend_addr :
               (dual | ~res) ? reg_update_address : wb_add;
    sel_data = (state == PEND) ? pend_data :
               (dual | ~res) ? base_register_update_content : wb_content;
    sel_pc = sel_we & (sel_addr == 4'(pc_index));
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      pend_addr <= '0;
      pend_data <= '0;
      rf_we <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pc_load <= 1'b0;
      pc_value <= '0;
      retired_count <= '0;
    end else begin
      rf_we <= sel_we & ~sel_pc;
      pc_load <= sel_pc;
      if (sel_we & ~sel_pc) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
      if (sel_pc) pc_value <= sel_data;
      if (state == IDLE && (res | base)) retired_count <= retired_count + 32'd1;
      if (state == IDLE && dual) begin
        pend_addr <= wb_add;
        pend_data <= wb_content;
        state <= PEND;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb_wb_writeback_unit: directed vectors for the write-back unit
module tb_wb_writeback_unit;
  logic clock = 1'b0;
  logic reset_n;
  logic [1:0] wb_control;
  logic [31:0] wb_content, base_register_update_content;
  logic [3:0] wb_add, reg_update_address;
  logic stall, rf_we, pc_load;
  logic [3:0] rf_waddr;
  logic [31:0] rf_wdata, pc_value, retired_count;
  int errors = 0;
  int checks = 0;

  wb_writeback_unit dut (
    .clock(clock),
    .reset_n(reset_n),
    .wb_control(wb_control),
    .wb_content(wb_content),
    .base_register_update_content(base_register_update_content),
    .wb_add(wb_add),
    .reg_update_address(reg_update_address),
    .stall(stall),
    .rf_we(rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata),
    .pc_load(pc_load),
    .pc_value(pc_value),
    .retired_count(retired_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] c, input logic [3:0] a, input logic [31:0] d,
                       input logic [3:0] ra, input logic [31:0] rd);
    wb_control = c;
    wb_add = a;
    wb_content = d;
    reg_update_address = ra;
    base_register_update_content = rd;
    #1;
  endtask

  task automatic rf_write(input string tag, input logic [3:0] a, input logic [31:0] d, input logic [31:0] cnt);
    chk({tag, "_we"}, 32'(rf_we), 32'd1);
    chk({tag, "_pc"}, 32'(pc_load), 32'd0);
    chk({tag, "_addr"}, 32'(rf_waddr), 32'(a));
    chk({tag, "_data"}, rf_wdata, d);
    chk({tag, "_cnt"}, retired_count, cnt);
  endtask

  initial begin
    reset_n = 1'b1;
    drive(2'b11, 4'd2, 32'h11, 4'd5, 32'h104);
    reset_n = 1'b0;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    tick;
    tick;
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_pc", 32'(pc_load), 32'd0);
    chk("rst_addr", 32'(rf_waddr), 32'd0);
    chk("rst_data", rf_wdata, 32'd0);
    chk("rst_pcv", pc_value, 32'd0);
    chk("rst_cnt", retired_count, 32'd0);
    chk("rst_stall2", 32'(stall), 32'd0);
    drive(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    reset_n = 1'b1;
    tick;
    chk("idle_cnt", retired_count, 32'd0);
    chk("idle_we", 32'(rf_we), 32'd0);
    // single write
    drive(2'b01, 4'd3, 32'hDEADBEEF, 4'd9, 32'h5);
    chk("single_stall", 32'(stall), 32'd0);
    tick;
    rf_write("single", 4'd3, 32'hDEADBEEF, 32'd1);
    drive(2'b00, 4'd3, 32'hDEADBEEF, 4'd9, 32'h5);
    tick;
    chk("single_off", 32'(rf_we), 32'd0);
    chk("single_hold", 32'(rf_waddr), 32'd3);
    chk("single_cnt2", retired_count, 32'd1);
    // dual write: base first then result, stall in first cycle only
    drive(2'b11, 4'd2, 32'h11, 4'd5, 32'h104);
    chk("dual_stall1", 32'(stall), 32'd1);
    tick;
    rf_write("dual_a", 4'd5, 32'h104, 32'd2);
    chk("dual_stall2", 32'(stall), 32'd0);
    tick;
    rf_write("dual_b", 4'd2, 32'h11, 32'd2);
    // back-to-back dual, no bubble
    drive(2'b11, 4'd6, 32'h66, 4'd9, 32'h99);
    chk("b2b_stall1", 32'(stall), 32'd1);
    tick;
    rf_write("b2b_a", 4'd9, 32'h99, 32'd3);
    chk("b2b_stall2", 32'(stall), 32'd0);
    tick;
    rf_write("b2b_b", 4'd6, 32'h66, 32'd3);
    // collision: result wins, single write
    drive(2'b11, 4'd7, 32'hA, 4'd7, 32'hB);
    chk("coll_stall", 32'(stall), 32'd0);
    tick;
    rf_write("coll", 4'd7, 32'hA, 32'd4);
    drive(2'b00, 4'd7, 32'hA, 4'd7, 32'hB);
    tick;
    chk("coll_off", 32'(rf_we), 32'd0);
    // PC write
    drive(2'b01, 4'd15, 32'h8000, 4'd1, 32'h0);
    tick;
    chk("pc_load", 32'(pc_load), 32'd1);
    chk("pc_value", pc_value, 32'h8000);
    chk("pc_rfwe", 32'(rf_we), 32'd0);
    chk("pc_cnt", retired_count, 32'd5);
    // dual with base to PC
    drive(2'b11, 4'd4, 32'h44, 4'd15, 32'h200);
    chk("dpc_stall", 32'(stall), 32'd1);
    tick;
    chk("dpc_load", 32'(pc_load), 32'd1);
    chk("dpc_value", pc_value, 32'h200);
    chk("dpc_rfwe", 32'(rf_we), 32'd0);
    tick;
    rf_write("dpc_b", 4'd4, 32'h44, 32'd6);
    // reset during PEND drops the pending write
    drive(2'b11, 4'd1, 32'h10, 4'd8, 32'h80);
    tick;
    rf_write("rp_a", 4'd8, 32'h80, 32'd7);
    reset_n = 1'b0;
    #1;
    chk("rp_we", 32'(rf_we), 32'd0);
    chk("rp_cnt", retired_count, 32'd0);
    chk("rp_stall", 32'(stall), 32'd0);
    chk("rp_addr", 32'(rf_waddr), 32'd0);
    drive(2'b00, 4'd1, 32'h10, 4'd8, 32'h80);
    reset_n = 1'b1;
    tick;
    chk("rp_nowrite", 32'(rf_we), 32'd0);
    chk("rp_nopc", 32'(pc_load), 32'd0);
    drive(2'b01, 4'd3, 32'h33, 4'd8, 32'h80);
    chk("rp_next_stall", 32'(stall), 32'd0);
    tick;
    rf_write("rp_next", 4'd3, 32'h33, 32'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
